bcdtobin: RTL and testbench

Sequential BCD-to-binary converter using the reverse double-dabble algorithm (shift right, subtract 3 from any digit >= 8). It is the inverse companion of the team's binary-to-BCD converter and uses the same start/ready/done handshake, so the two can be chained for round-trip checks. It accepts N_DIGITS packed BCD digits and returns the unsigned binary value after a fixed number of cycles.

---
 rtl/bcdtobin_pkg.sv | 15 +
 rtl/bcdtobin_digit_sub3.sv | 17 +
 rtl/bcdtobin.sv | 136 +++++++++++++
 tb/tb_bcdtobin.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bcdtobin_pkg.sv
// Shared types and constants for the bcdtobin BCD-to-binary converter.
// Optional build macro: BCDTOBIN_ERR_EN (invalid-digit detection).
package bcdtobin_pkg;

    typedef enum logic [1:0] {
        S_READY = 2'd0,
        S_OP    = 2'd1,
        S_DONE  = 2'd2
    } t_state;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_ADJ_THRESH = 8;
    localparam int BCD_ADJ_SUB    = 3;

endpackage

// File: rtl/bcdtobin_digit_sub3.sv
// One digit of the reverse double-dabble correction: digits >= 8 after a
// right shift carried a weight-8 bit that really stands for 5, so subtract 3.
module bcd_digit_sub3
    import bcdtobin_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) begin
            dout = din - BCD_DIGIT_W'(BCD_ADJ_SUB);
        end
    end

endmodule

// File: rtl/bcdtobin.sv
// Sequential BCD-to-binary converter (reverse double-dabble), start/ready/done
// handshake. Define BCDTOBIN_ERR_EN to add invalid-digit detection and o_err.
//
// Handshake: i_start is sampled only while o_ready is high; an accepted start
// produces exactly one o_done pulse, and o_bin is valid from that pulse until
// the next accepted start. o_ready and o_done decode the state register.
module bcdtobin
    import bcdtobin_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 14
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [BCD_DIGIT_W*N_DIGITS-1:0] i_bcd,
    output logic                        o_ready,
    output logic                        o_done,
    output logic [BIN_W-1:0]            o_bin,
`ifdef BCDTOBIN_ERR_EN
    output logic                        o_err,
`endif
    output t_state                      o_state
);

    localparam int BCD_W = BCD_DIGIT_W * N_DIGITS;
    localparam int IDX_W = $clog2(BIN_W + 2);
    localparam logic [IDX_W-1:0] IDX_LOAD = IDX_W'(BIN_W + 1);

    t_state           r_state, state_nxt;
    logic [BCD_W-1:0] r_bcd, bcd_nxt;
    logic [BIN_W-1:0] r_bin, bin_nxt;
    logic [IDX_W-1:0] r_index, idx_nxt;

    logic [BCD_W-1:0] bcd_shift, bcd_adj;
    logic [BIN_W-1:0] bin_shift;

    assign bcd_shift = {1'b0, r_bcd[BCD_W-1:1]};
    assign bin_shift = {r_bcd[0], r_bin[BIN_W-1:1]};

    for (genvar d = 0; d < N_DIGITS; d++) begin : g_adj
        bcd_digit_sub3 u_sub3 (
            .din  (bcd_shift[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (bcd_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

`ifdef BCDTOBIN_ERR_EN
    logic r_err, err_nxt;
    logic bcd_invalid;

    always_comb begin
        bcd_invalid = 1'b0;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (i_bcd[d*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(9)) begin
                bcd_invalid = 1'b1;
            end
        end
    end

    assign o_err = r_err;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_READY;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_index <= '0;
`ifdef BCDTOBIN_ERR_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= state_nxt;
            r_bcd   <= bcd_nxt;
            r_bin   <= bin_nxt;
            r_index <= idx_nxt;
`ifdef BCDTOBIN_ERR_EN
            r_err   <= err_nxt;
`endif
        end
    end

    // The first S_OP cycle (index = BIN_W+1) only settles; the next BIN_W
    // cycles shift, and index 0 hands over to S_DONE.
    always_comb begin
        state_nxt = r_state;
        bcd_nxt   = r_bcd;
        bin_nxt   = r_bin;
        idx_nxt   = r_index;
`ifdef BCDTOBIN_ERR_EN
        err_nxt   = r_err;
`endif
        case (r_state)
            S_READY: begin
                if (i_start) begin
`ifdef BCDTOBIN_ERR_EN
                    err_nxt = bcd_invalid;
                    bin_nxt = '0;
                    if (bcd_invalid) begin
                        state_nxt = S_DONE;
                    end else begin
                        bcd_nxt   = i_bcd;
                        idx_nxt   = IDX_LOAD;
                        state_nxt = S_OP;
                    end
`else
                    bcd_nxt   = i_bcd;
                    bin_nxt   = '0;
                    idx_nxt   = IDX_LOAD;
                    state_nxt = S_OP;
`endif
                end
            end
            S_OP: begin
                if (r_index == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    if (r_index != IDX_LOAD) begin
                        bcd_nxt = bcd_adj;
                        bin_nxt = bin_shift;
                    end
                    idx_nxt = r_index - IDX_W'(1);
                end
            end
            S_DONE:  state_nxt = S_READY;
            default: state_nxt = S_READY;
        endcase
    end

    assign o_ready = (r_state == S_READY);
    assign o_done  = (r_state == S_DONE);
    assign o_bin   = r_bin;
    assign o_state = r_state;

endmodule

// File: tb/tb_bcdtobin.sv
// Self-checking bench for bcdtobin: directed vectors, queue-based scoreboard
// checked by an independent monitor on o_done.
module tb_bcdtobin;
    import bcdtobin_pkg::*;

    localparam int N_DIGITS = 4;
    localparam int BIN_W    = 14;
    localparam int BCD_W    = 16;
    localparam int W        = BIN_W + 2;   // {check_bin, exp_err, exp_bin}

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [BCD_W-1:0] bcd;
    logic             ready;
    logic             done;
    logic [BIN_W-1:0] bin;
    t_state           state;
`ifdef BCDTOBIN_ERR_EN
    logic             err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0]     exp_q[$];
    logic [W-1:0]     mon_e;
    logic [BIN_W-1:0] last_bin;

    bcdtobin #(.N_DIGITS(N_DIGITS), .BIN_W(BIN_W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_bcd   (bcd),
        .o_ready (ready),
        .o_done  (done),
        .o_bin   (bin),
`ifdef BCDTOBIN_ERR_EN
        .o_err   (err),
`endif
        .o_state (state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic logic [BCD_W-1:0] to_bcd(input int v);
        logic [BCD_W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < N_DIGITS; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            check("ready_done_excl", {31'd0, ready & done}, 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e[W-1]) check("bin", 32'(bin), 32'(mon_e[BIN_W-1:0]));
`ifdef BCDTOBIN_ERR_EN
                    check("err", 32'(err), 32'(mon_e[BIN_W]));
`endif
                end
            end
        end
    end

    // driver: one conversion, measures start-edge to o_done latency
    task automatic convert(input logic [BCD_W-1:0] v, input logic [BIN_W-1:0] exp_bin,
                           input bit chk, input bit exp_err, input int exp_lat, input bit poke);
        int waited;
        int lat;
        waited = 0;
        while (!ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", 32'(ready), 32'd1);
        bcd   = v;
        start = 1'b1;
        exp_q.push_back({chk, exp_err, exp_bin});
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (poke && lat == 5) begin
                bcd   = 16'h7777;
                start = 1'b1;
            end
            if (lat == 6) start = 1'b0;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        @(negedge clk);
        last_bin = exp_bin;
    endtask

    initial begin
        int cyc;
        int dones;
        int ready_cnt;
        int done_at[3];
        rst   = 1'b1;
        start = 1'b0;
        bcd   = '0;
        repeat (2) @(negedge clk);
        check("rst_bin", 32'(bin), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(state), 32'(S_READY));
        rst = 1'b0;
        @(negedge clk);

        // reset mid-conversion
        bcd   = 16'h1234;
        start = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 14'd1234});
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_bin", 32'(bin), 32'd0);
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        convert(16'h0042, 14'd42, 1'b1, 1'b0, 16, 1'b0);

        // basic vectors, one with a start poked during S_OP
        convert(16'h0000, 14'd0,    1'b1, 1'b0, 16, 1'b0);
        convert(16'h0001, 14'd1,    1'b1, 1'b0, 16, 1'b0);
        convert(16'h1234, 14'd1234, 1'b1, 1'b0, 16, 1'b1);
        convert(16'h9999, 14'h270F, 1'b1, 1'b0, 16, 1'b0);
        repeat (5) @(negedge clk);
        check("bin_hold", 32'(bin), 32'(last_bin));

        // start held high: back-to-back conversions every 18 cycles
        bcd = 16'h0777;
        repeat (3) exp_q.push_back({1'b1, 1'b0, 14'd777});
        start     = 1'b1;
        cyc       = 0;
        dones     = 0;
        ready_cnt = 0;
        @(posedge clk);
        while (dones < 3 && cyc < 80) begin
            #1;
            if (ready) ready_cnt++;
            if (done) begin
                done_at[dones] = cyc;
                dones++;
                if (dones == 3) start = 1'b0;
            end
            if (dones < 3) begin
                @(posedge clk);
                cyc++;
            end
        end
        check("held_dones", 32'(dones), 32'd3);
        check("held_first", 32'(done_at[0]), 32'd16);
        check("held_period1", 32'(done_at[1] - done_at[0]), 32'd18);
        check("held_period2", 32'(done_at[2] - done_at[1]), 32'd18);
        check("held_ready_cycles", 32'(ready_cnt), 32'd2);
        @(negedge clk);
        @(negedge clk);
        check("held_no_restart", 32'(state), 32'(S_READY));

        // invalid digit handling
`ifdef BCDTOBIN_ERR_EN
        convert(16'h12A4, 14'd0,   1'b1, 1'b1, 0,  1'b0);
        convert(16'h0500, 14'd500, 1'b1, 1'b0, 16, 1'b0);
`else
        convert(16'h12A4, 14'd0,   1'b0, 1'b0, 16, 1'b0);
        convert(16'h0500, 14'd500, 1'b1, 1'b0, 16, 1'b0);
`endif

        // round trip across the range
        for (int v = 0; v <= 9999; v += 7) begin
            convert(to_bcd(v), 14'(v), 1'b1, 1'b0, 16, 1'b0);
        end
        convert(to_bcd(9999), 14'd9999, 1'b1, 1'b0, 16, 1'b0);
        repeat (3) @(negedge clk);
        check("final_hold", 32'(bin), 32'(last_bin));
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
